// File: rtl/ext_int_controller_pkg.sv
// Shared constants, types and helpers for the external interrupt controller.
// Register indices decode bus_addr[3:2]; IDs are 1-based source numbers, 0 means none.
package ext_int_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned ID_W    = 5;
    localparam int unsigned MAX_SRC = 31;

    localparam logic [1:0] REG_PENDING   = 2'd0;
    localparam logic [1:0] REG_ENABLE    = 2'd1;
    localparam logic [1:0] REG_EDGE_MODE = 2'd2;
    localparam logic [1:0] REG_CLAIM     = 2'd3;

    typedef logic [ID_W-1:0] irq_id_t;

    typedef enum logic {
        ST_IDLE,
        ST_SERVICE
    } svc_state_t;

    // Decoded view of one accepted register access.
    typedef struct packed {
        logic              write;
        logic [1:0]        idx;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // Lowest set bit wins; returns its index + 1, or 0 when the vector is empty.
    function automatic irq_id_t prio_encode(input logic [DATA_W-1:0] vec);
        irq_id_t id;
        id = '0;
        for (int i = int'(MAX_SRC) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/ext_int_controller_if.sv
// Register bus between software master and the interrupt controller.
interface ext_int_controller_if;
    import ext_int_pkg::*;

    logic              bus_req;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_write, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_write, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/ext_int_controller_sync.sv
// Per-source synchroniser chain plus edge history register.
// level is the last synchroniser stage; rise_c flags a fresh 0->1 on it.
module int_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq,
    output logic level,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~prev_q;

endmodule

// File: rtl/ext_int_controller.sv
// External interrupt controller: synchronises device lines, tracks pending/enable,
// and hands out fixed-priority claims over a single-cycle register bus.
module ext_int_controller
    import ext_int_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_SRC-1:0]   irq_src,
    ext_int_controller_if.slave  bus,
    output logic                 ext_int
);

    svc_state_t        state, state_nx;
    irq_id_t           claimed_id, claimed_id_nx;

    logic [NUM_SRC-1:0] sync_lvl;
    logic [NUM_SRC-1:0] sync_rise_c;
    logic [NUM_SRC-1:0] pending, pending_nx;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] claim_clr;

    bus_cmd_t          cmd;
    logic              accept;
    logic              wr_enable;
    logic              wr_edge_mode;
    logic              do_claim;
    logic              do_complete;
    irq_id_t           claim_id_c;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_bits;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        int_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .irq     (irq_src[i]),
            .level   (sync_lvl[i]),
            .rise_c  (sync_rise_c[i])
        );
    end

    // Word offset bits and write-data bits above the register width carry no meaning.
    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata};

    // Bus decode; a request overlapping the previous ack is dropped entirely.
    always_comb begin
        cmd          = '{write: bus.bus_write, idx: bus.bus_addr[3:2], wdata: bus.bus_wdata};
        accept       = bus.bus_req & ~bus.bus_ack;
        wr_enable    = accept & cmd.write & (cmd.idx == REG_ENABLE);
        wr_edge_mode = accept & cmd.write & (cmd.idx == REG_EDGE_MODE);
        claim_id_c   = (state == ST_IDLE) ? prio_encode(DATA_W'(pending & enable)) : '0;
        do_claim     = accept & ~cmd.write & (cmd.idx == REG_CLAIM) & (claim_id_c != '0);
        do_complete  = accept & cmd.write & (cmd.idx == REG_CLAIM) &
                       (state == ST_SERVICE) & (cmd.wdata[ID_W-1:0] == claimed_id);

        claim_clr = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            claim_clr[i] = do_claim && (claim_id_c == ID_W'(i + 1));
        end

        rdata_c = '0;
        case (cmd.idx)
            REG_PENDING:   rdata_c = DATA_W'(pending);
            REG_ENABLE:    rdata_c = DATA_W'(enable);
            REG_EDGE_MODE: rdata_c = DATA_W'(edge_mode);
            REG_CLAIM:     rdata_c = DATA_W'(claim_id_c);
        endcase
    end

    // Edge sources latch rises (a new rise beats a same-cycle claim); level sources follow the line.
    always_comb begin
        pending_nx = (edge_mode & (sync_rise_c | (pending & ~claim_clr))) |
                     (~edge_mode & sync_lvl);
    end

    // In-service tracking: one claim outstanding at a time.
    always_comb begin
        state_nx      = state;
        claimed_id_nx = claimed_id;
        case (state)
            ST_IDLE: begin
                if (do_claim) begin
                    state_nx      = ST_SERVICE;
                    claimed_id_nx = claim_id_c;
                end
            end
            ST_SERVICE: begin
                if (do_complete) begin
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            claimed_id <= '0;
        end else begin
            state      <= state_nx;
            claimed_id <= claimed_id_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending       <= '0;
            enable        <= '0;
            edge_mode     <= '0;
            ext_int       <= 1'b0;
            bus.bus_ack   <= 1'b0;
            bus.bus_rdata <= '0;
        end else begin
            pending       <= pending_nx;
            if (wr_enable) begin
                enable <= cmd.wdata[NUM_SRC-1:0];
            end
            if (wr_edge_mode) begin
                edge_mode <= cmd.wdata[NUM_SRC-1:0];
            end
            ext_int       <= (state == ST_IDLE) && (|(pending & enable));
            bus.bus_ack   <= accept;
            bus.bus_rdata <= (accept && !cmd.write) ? rdata_c : '0;
        end
    end

endmodule

// File: tb/tb_ext_int_controller.sv
// Scoreboard bench for ext_int_controller: expected read data is queued at issue
// and compared when bus_ack appears; interrupt timing is checked cycle by cycle.
module tb_ext_int_controller;
    import ext_int_pkg::*;

    localparam int unsigned NUM_SRC = 8;

    logic               clk;
    logic               reset_n;
    logic [NUM_SRC-1:0] irq_src;
    logic               ext_int;

    ext_int_controller_if bif ();

    ext_int_controller #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_src (irq_src),
        .bus     (bif),
        .ext_int (ext_int)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic        mon_en = 1'b0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns two negedges later with the ack pulse checked.
    task automatic bus_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                            input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bif.bus_req   = 1'b1;
        bif.bus_write = wr;
        bif.bus_addr  = addr;
        bif.bus_wdata = data;
        @(negedge clk);
        bif.bus_req   = 1'b0;
        bif.bus_write = 1'b0;
        bif.bus_wdata = '0;
        check_eq({tag, "_ack"}, 32'(bif.bus_ack), 32'd1);
        @(negedge clk);
        check_eq({tag, "_ack_end"}, 32'(bif.bus_ack), 32'd0);
    endtask

    task automatic bus_rd(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        bus_xfer(1'b0, addr, 32'd0, exp, tag);
    endtask

    task automatic bus_wr(input logic [3:0] addr, input logic [31:0] data, input string tag);
        bus_xfer(1'b1, addr, data, 32'd0, tag);
    endtask

    // Scoreboard consumer: every ack must match a queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bif.bus_ack) begin
                check_eq("sb_pop", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq(tag_q.pop_front(), bif.bus_rdata, exp_q.pop_front());
                end
            end else begin
                check_eq("rdata_idle", bif.bus_rdata, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        irq_src       = '0;
        bif.bus_req   = 1'b0;
        bif.bus_write = 1'b0;
        bif.bus_addr  = '0;
        bif.bus_wdata = '0;
        wait_cycles(3);
        check_eq("rst_ext_int", 32'(ext_int), 32'd0);
        check_eq("rst_ack", 32'(bif.bus_ack), 32'd0);
        check_eq("rst_rdata", bif.bus_rdata, 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Reset values of all registers; ENABLE also via an unaligned address.
        bus_rd(4'h0, 32'h0, "rst_pending");
        bus_rd(4'h5, 32'h0, "rst_enable");
        bus_rd(4'h8, 32'h0, "rst_edge_mode");
        bus_rd(4'hC, 32'h0, "rst_claim");
        check_eq("rst_ext_int_run", 32'(ext_int), 32'd0);

        // Back-to-back request: the second cycle collides with the ack and is dropped.
        exp_q.push_back(32'h0);
        tag_q.push_back("drop_first");
        bif.bus_req   = 1'b1;
        bif.bus_write = 1'b1;
        bif.bus_addr  = 4'h4;
        bif.bus_wdata = 32'h11;
        @(negedge clk);
        bif.bus_wdata = 32'h22;
        @(negedge clk);
        bif.bus_req   = 1'b0;
        bif.bus_write = 1'b0;
        check_eq("drop_no_ack", 32'(bif.bus_ack), 32'd0);
        bus_rd(4'h4, 32'h11, "drop_enable");
        bus_wr(4'h0, 32'hFF, "pending_ro_wr");
        bus_rd(4'h0, 32'h0, "pending_ro_rd");

        // Single edge source, one-cycle pulse: latency to ext_int and claim.
        bus_wr(4'h4, 32'h01, "t2_enable");
        bus_wr(4'h8, 32'h01, "t2_edge");
        irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        wait_cycles(2);
        check_eq("t2_ext_int_early", 32'(ext_int), 32'd0);
        wait_cycles(1);
        check_eq("t2_ext_int_edge4", 32'(ext_int), 32'd1);
        bus_rd(4'h0, 32'h01, "t2_pending");
        bus_rd(4'hC, 32'd1, "t2_claim");
        check_eq("t2_ext_int_claimed", 32'(ext_int), 32'd0);
        bus_rd(4'h0, 32'h00, "t2_pending_clr");
        bus_wr(4'hC, 32'd1, "t2_complete");

        // Two edge sources rise together: lowest wins, second waits for completion.
        bus_wr(4'h4, 32'h24, "t3_enable");
        bus_wr(4'h8, 32'h24, "t3_edge");
        irq_src = 8'h24;
        wait_cycles(4);
        check_eq("t3_ext_int", 32'(ext_int), 32'd1);
        bus_rd(4'hC, 32'd3, "t3_claim_a");
        bus_rd(4'hC, 32'd0, "t3_claim_busy");
        check_eq("t3_ext_int_busy", 32'(ext_int), 32'd0);
        bus_wr(4'hC, 32'd3, "t3_complete_a");
        check_eq("t3_ext_int_reassert", 32'(ext_int), 32'd1);
        bus_rd(4'hC, 32'd6, "t3_claim_b");
        bus_wr(4'hC, 32'd6, "t3_complete_b");
        irq_src = 8'h00;
        wait_cycles(4);
        check_eq("t3_ext_int_idle", 32'(ext_int), 32'd0);
        bus_rd(4'h0, 32'h00, "t3_pending");

        // Level source: claim leaves pending set; wrong-ID completion is ignored.
        bus_wr(4'h8, 32'h00, "t4_edge");
        bus_wr(4'h4, 32'h02, "t4_enable");
        irq_src = 8'h02;
        wait_cycles(4);
        check_eq("t4_ext_int", 32'(ext_int), 32'd1);
        bus_rd(4'hC, 32'd2, "t4_claim");
        bus_rd(4'h0, 32'h02, "t4_pending_held");
        check_eq("t4_ext_int_claimed", 32'(ext_int), 32'd0);
        bus_wr(4'hC, 32'd4, "t5_complete_wrong");
        check_eq("t5_ext_int_wrong", 32'(ext_int), 32'd0);
        bus_rd(4'hC, 32'd0, "t5_claim_busy");
        bus_wr(4'hC, 32'd2, "t5_complete_ok");
        check_eq("t5_ext_int_reassert", 32'(ext_int), 32'd1);
        irq_src = 8'h00;
        wait_cycles(3);
        check_eq("t4_ext_int_hold", 32'(ext_int), 32'd1);
        wait_cycles(1);
        check_eq("t4_ext_int_drop", 32'(ext_int), 32'd0);
        bus_rd(4'h0, 32'h00, "t4_pending_drop");

        // Reset with a claim outstanding and lines high.
        bus_wr(4'h4, 32'h02, "t6_enable");
        irq_src = 8'h0A;
        wait_cycles(4);
        bus_rd(4'hC, 32'd2, "t6_claim");
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_ext_int", 32'(ext_int), 32'd0);
        check_eq("t6_rst_ack", 32'(bif.bus_ack), 32'd0);
        reset_n = 1'b1;
        bus_rd(4'h0, 32'h0, "t6_pending_rst");
        bus_rd(4'h4, 32'h0, "t6_enable_rst");
        bus_rd(4'h8, 32'h0, "t6_edge_rst");
        bus_rd(4'hC, 32'h0, "t6_claim_rst");
        wait_cycles(2);
        bus_rd(4'h0, 32'h0A, "t6_pending_level");
        check_eq("t6_ext_int_masked", 32'(ext_int), 32'd0);
        bus_wr(4'h4, 32'h02, "t6_enable2");
        check_eq("t6_ext_int_enabled", 32'(ext_int), 32'd1);
        bus_rd(4'hC, 32'd2, "t6_claim_after_rst");
        bus_wr(4'hC, 32'd2, "t6_complete");
        irq_src = 8'h00;
        wait_cycles(2);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
